// File: rtl/core_apb_bridge.sv
// -----------------------------------------------------------------------------
// core_apb_bridge
//
// Converts the core's request/response register-access port into a single
// APB4 master. Exactly one transfer is in flight at a time; the response
// channel is registered and held until the core accepts it.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. Once raised, rsp_valid and its
// payload stay stable until that transfer happens. req_ready depends on the
// FSM state only and never on req_valid.
//
// Parameters:
//   ADDR_WIDTH      width of req_addr / paddr
//   DATA_WIDTH      width of write/read data (strobes are DATA_WIDTH/8 wide)
//   TIMEOUT_CYCLES  ACCESS-phase cycle limit, used only with the timeout
//                   build option; must be >= 1
//
// Build option:
//   CORE_APB_TIMEOUT_EN  when defined, an ACCESS phase that sees pready low
//                        for TIMEOUT_CYCLES cycles is abandoned and answered
//                        with rsp_err=1, rsp_rdata=0. When undefined, ACCESS
//                        waits for pready indefinitely.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_addr/req_write/req_wdata/req_wstrb/req_prot   request payload
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         response payload (rdata is 0 for writes)
//   psel/penable/paddr/pwrite/pwdata/pstrb/pprot      APB master outputs
//   prdata/pslverr/pready     APB slave returns
//
// The FSM state is held in the signal 'state' (state_t) for checkers to bind.
// -----------------------------------------------------------------------------
module core_apb_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic                    req_write,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   input  logic [2:0]              req_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    psel,
   output logic                    penable,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [2:0]              pprot,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pslverr,
   input  logic                    pready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state;

   // Elaboration-time guard: a zero limit would abandon every transfer.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("core_apb_bridge: TIMEOUT_CYCLES must be >= 1");
   end

   // High in the ACCESS cycle that would be abandoned if pready stays low.
   logic timeout_hit;

`ifdef CORE_APB_TIMEOUT_EN
   // Counter width: 8 bits unless the limit needs more, capped at 16.
   localparam int TMO_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

   logic [TMO_W-1:0] tmo_cnt;

   // tmo_cnt holds the number of pready-low ACCESS cycles already seen, so
   // the limit is reached in the cycle where it equals TIMEOUT_CYCLES-1.
   assign timeout_hit = (state == ACCESS) && !pready &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
      end else if (state == SETUP) begin
         tmo_cnt <= '0;
      end else if (state == ACCESS && !pready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         psel      <= 1'b0;
         penable   <= 1'b0;
         paddr     <= '0;
         pwrite    <= 1'b0;
         pwdata    <= '0;
         pstrb     <= '0;
         pprot     <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  paddr  <= req_addr;
                  pwrite <= req_write;
                  pwdata <= req_wdata;
                  // Reads never carry byte enables on APB4.
                  pstrb  <= req_write ? req_wstrb : '0;
                  pprot  <= req_prot;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end

            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end

            ACCESS: begin
               // A real completion takes priority over a timeout in the
               // same cycle.
               if (pready) begin
                  rsp_rdata <= pwrite ? '0 : prdata;
                  rsp_err   <= pslverr;
                  rsp_valid <= 1'b1;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  state     <= RESP;
               end else if (timeout_hit) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  state     <= RESP;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_core_apb_bridge
//
// Drives the bridge through a table of directed transfers, a batch of random
// transfers whose expected response comes from a transfer-level model, and a
// few hand-written sequences: back-to-back spacing, reset mid-ACCESS and the
// stuck-pready case (timeout when CORE_APB_TIMEOUT_EN is defined, indefinite
// wait otherwise). The DUT is built with TIMEOUT_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_core_apb_bridge;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 4;

   // ---------------------------------------------------------------- signals
   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;
   logic          req_write;
   logic [DW-1:0] req_wdata;
   logic [SW-1:0] req_wstrb;
   logic [2:0]    req_prot;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          psel;
   logic          penable;
   logic [AW-1:0] paddr;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic [2:0]    pprot;
   logic [DW-1:0] prdata;
   logic          pslverr;
   logic          pready;

   core_apb_bridge #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_prot  (req_prot),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pprot     (pprot),
      .prdata    (prdata),
      .pslverr   (pslverr),
      .pready    (pready)
   );

   // ------------------------------------------------------- clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Advance one cycle; sample and drive 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ scoreboard
   int total = 0;
   int bad   = 0;
   logic [DW:0] exp_q[$];   // {err, rdata} per accepted transfer

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [2:0]    prot;
      logic [DW-1:0] prdata;
      logic          slverr;
      int            waits;     // pready-low ACCESS cycles before completion
      int            rdelay;    // cycles rsp_ready is held low in RESP
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                               input logic [2:0] prot, input logic [DW-1:0] rd,
                               input logic slverr, input int waits, input int rdelay,
                               input logic [DW-1:0] exp_rdata, input logic exp_err);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.prot = prot;
      v.prdata = rd; v.slverr = slverr; v.waits = waits; v.rdelay = rdelay;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err;
      return v;
   endfunction

   // Transfer-level reference: what the core should see for one APB access.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_rdata = v.wr ? '0 : v.prdata;
      r.exp_err   = v.slverr;
      return r;
   endfunction

   // ---------------------------------------------------------- driver tasks
   // Present a request and wait (bounded) for it to be accepted.
   task automatic issue(input vec_t v, output bit accepted, output int acc_cyc);
      accepted  = 1'b0;
      acc_cyc   = 0;
      req_valid = 1'b1;
      req_addr  = v.addr;
      req_write = v.wr;
      req_wdata = v.wdata;
      req_wstrb = v.wstrb;
      req_prot  = v.prot;
      for (int i = 0; i < 20 && !accepted; i++) begin
         if (req_ready) accepted = 1'b1;
         step();
      end
      req_valid = 1'b0;
      acc_cyc   = cyc;
      chk("accept", accepted, 1);
   endtask

   // Full transfer: request, APB slave behaviour, response with backpressure.
   task automatic xfer(input vec_t v, output int acc_cyc);
      bit          accepted;
      logic [SW-1:0] exp_strb;
      logic [DW:0] exp;
      exp_strb = v.wr ? v.wstrb : '0;
      issue(v, accepted, acc_cyc);
      if (!accepted) return;
      exp_q.push_back({v.exp_err, v.exp_rdata});

      // SETUP
      chk("setup_psel_pen", {psel, penable}, 2'b10);
      chk("setup_req_ready", req_ready, 0);
      chk("setup_rsp_valid", rsp_valid, 0);
      chk("setup_paddr", paddr, v.addr);
      chk("setup_pwrite", pwrite, v.wr);
      chk("setup_pwdata", pwdata, v.wdata);
      chk("setup_pstrb", pstrb, exp_strb);
      chk("setup_pprot", pprot, v.prot);
      step();

      // ACCESS, with garbage on prdata/pslverr while pready is low
      for (int w = 0; w <= v.waits; w++) begin
         chk("access_psel_pen", {psel, penable}, 2'b11);
         chk("access_rsp_valid", rsp_valid, 0);
         chk("access_paddr", paddr, v.addr);
         chk("access_pwdata", pwdata, v.wdata);
         chk("access_pstrb", pstrb, exp_strb);
         chk("access_pprot", pprot, v.prot);
         rsp_ready = 1'($urandom_range(0, 1));
         if (w == v.waits) begin
            pready = 1'b1; prdata = v.prdata; pslverr = v.slverr;
         end else begin
            pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom_range(0, 1));
         end
         step();
      end
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;

      // RESP, with a bait request presented while the response is stalled
      exp = exp_q.pop_front();
      for (int d = 0; d <= v.rdelay; d++) begin
         chk("resp_valid", rsp_valid, 1);
         chk("resp_rdata", rsp_rdata, exp[DW-1:0]);
         chk("resp_err", rsp_err, exp[DW]);
         chk("resp_psel_pen", {psel, penable}, 2'b00);
         chk("resp_req_ready", req_ready, 0);
         if (d == v.rdelay) begin
            rsp_ready = 1'b1; req_valid = 1'b0;
         end else begin
            rsp_ready = 1'b0; req_valid = 1'b1; req_addr = $urandom;
         end
         step();
      end
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      chk("done_rsp_valid", rsp_valid, 0);
      chk("done_req_ready", req_ready, 1);
      chk("done_psel", psel, 0);
   endtask

   // Issue a read and step into the first ACCESS cycle, pready held low.
   task automatic start_stuck_read(output bit ok);
      vec_t v;
      int   acc;
      v = mk(1'b0, 32'h0000_0040, '0, 4'hF, 3'b000, '0, 1'b0, 0, 0, '0, 1'b0);
      pready = 1'b0;
      issue(v, ok, acc);
      if (ok) step();
   endtask

   // ------------------------------------------------------------- main test
   vec_t tbl[5];
   vec_t rv;
   int   acc_a, acc_b, acc_c;
   bit   ok;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
      req_wstrb = '0; req_prot = '0; rsp_ready = 1'b0; prdata = '0; pslverr = 1'b0;
      pready = 1'b0;

      tbl[0] = mk(1'b0, 32'h0800_0010, 32'h0, 4'hF, 3'b000, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0);
      tbl[1] = mk(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 3'b000, 32'hFFFF_FFFF, 1'b0, 3, 0, 32'h0, 1'b0);
      tbl[2] = mk(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b001, 32'hA5A5_A5A5, 1'b1, 0, 4, 32'hA5A5_A5A5, 1'b1);
      tbl[3] = mk(1'b1, 32'h0800_0020, 32'hCAFE_F00D, 4'h5, 3'b101, 32'h1111_1111, 1'b1, 1, 1, 32'h0, 1'b1);
      tbl[4] = mk(1'b0, 32'h0000_0008, 32'h5555_5555, 4'hA, 3'b010, 32'h0000_0001, 1'b0, 2, 0, 32'h0000_0001, 1'b0);

      repeat (3) step();

      // Reset state
      chk("rst_req_ready", req_ready, 1);
      chk("rst_psel_pen", {psel, penable}, 2'b00);
      chk("rst_paddr", paddr, 0);
      chk("rst_pwrite", pwrite, 0);
      chk("rst_pwdata", pwdata, 0);
      chk("rst_pstrb", pstrb, 0);
      chk("rst_pprot", pprot, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      rst = 1'b0;
      step();
      chk("post_rst_req_ready", req_ready, 1);

      // Directed table
      for (int i = 0; i < 5; i++) xfer(tbl[i], acc_a);

      // Back-to-back reads, rsp_ready high immediately: accepts 4 cycles apart
      rv = model(mk(1'b0, 32'h0000_0200, '0, '0, 3'b000, 32'h0000_00AA, 1'b0, 0, 0, '0, 1'b0));
      xfer(rv, acc_a);
      rv = model(mk(1'b0, 32'h0000_0204, '0, '0, 3'b000, 32'h0000_00BB, 1'b0, 0, 0, '0, 1'b0));
      xfer(rv, acc_b);
      rv = model(mk(1'b0, 32'h0000_0208, '0, '0, 3'b000, 32'h0000_00CC, 1'b0, 0, 0, '0, 1'b0));
      xfer(rv, acc_c);
      chk("b2b_spacing_1", acc_b - acc_a, 4);
      chk("b2b_spacing_2", acc_c - acc_b, 4);

      // Random transfers against the reference model
      for (int i = 0; i < 40; i++) begin
         rv = mk(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, TMO - 1), $urandom_range(0, 2), '0, 1'b0);
         xfer(model(rv), acc_a);
      end

      // Reset mid-ACCESS: transfer dropped, no response ever appears
      start_stuck_read(ok);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_psel_pen", {psel, penable}, 2'b00);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_req_ready", req_ready, 1);
      pready = 1'b1; prdata = 32'h7777_7777; rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("midrst_no_rsp", rsp_valid, 0);
         chk("midrst_no_psel", psel, 0);
      end
      pready = 1'b0; rsp_ready = 1'b0;

      // Stuck pready
      start_stuck_read(ok);
      prdata = 32'hBAD0_BAD0;
`ifdef CORE_APB_TIMEOUT_EN
      for (int k = 0; k < TMO; k++) begin
         chk("tmo_access", {psel, penable}, 2'b11);
         chk("tmo_no_rsp", rsp_valid, 0);
         step();
      end
      chk("tmo_psel_pen", {psel, penable}, 2'b00);
      chk("tmo_rsp_valid", rsp_valid, 1);
      chk("tmo_rsp_err", rsp_err, 1);
      chk("tmo_rsp_rdata", rsp_rdata, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("tmo_done_ready", req_ready, 1);
`else
      for (int k = 0; k < 20; k++) begin
         chk("stuck_access", {psel, penable}, 2'b11);
         chk("stuck_no_rsp", rsp_valid, 0);
         step();
      end
      pready = 1'b1;
      step();
      pready = 1'b0;
      chk("stuck_rsp_valid", rsp_valid, 1);
      chk("stuck_rsp_rdata", rsp_rdata, 32'hBAD0_BAD0);
      chk("stuck_rsp_err", rsp_err, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("stuck_done_ready", req_ready, 1);
`endif

      chk("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_apb_bridge.md
Name: core_apb_bridge

Overview:
- Upstream neighbour of the core APB splitter. Converts the core's request/response register-access port into a single APB4 master.
- Its APB outputs drive the splitter's slave side, which routes each transfer to the config-register block or the interrupt controller.
- One transfer in flight at a time, with a registered response channel.

Parameters:
ADDR_WIDTH, 32, width of req_addr/paddr
DATA_WIDTH, 32, width of write/read data; strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, ACCESS-phase cycle limit (used only with the optional feature); must be >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  bridge can accept a request
req_addr  in  ADDR_WIDTH  byte address
req_write  in  1  1 = write, 0 = read
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  DATA_WIDTH/8  byte enables
req_prot  in  3  protection attributes
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
rsp_err  out  1  slave error or timeout
psel  out  1  APB select
penable  out  1  APB enable
paddr  out  ADDR_WIDTH  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  APB read data
pslverr  in  1  APB error
pready  in  1  APB ready

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state=IDLE; psel=0; penable=0; paddr=0; pwrite=0; pwdata=0; pstrb=0; pprot=0; rsp_valid=0; rsp_rdata=0; rsp_err=0.
- req_ready = (state==IDLE). It is combinational from state only and never depends on req_valid.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid&&req_ready, register addr, write, wdata, prot and strobe into the APB output regs, then go to SETUP.
  - The strobe register takes req_wstrb for writes and is forced to 0 for reads.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite, pwdata, pstrb and pprot stay stable from SETUP until the transfer completes.
  - On pready=1: capture rsp_rdata = pwrite ? 0 : prdata and rsp_err = pslverr; set rsp_valid=1; drop psel and penable next cycle; go to RESP.
  - prdata and pslverr are ignored while pready=0.
- RESP:
  - rsp_valid=1, and rsp_rdata/rsp_err are held stable.
  - On rsp_ready=1, clear rsp_valid and go to IDLE.
- Latency: request accepted at cycle N; SETUP at N+1; ACCESS at N+2; with zero-wait pready, rsp_valid is high at N+3. Each pready wait state adds one cycle.
- Throughput: with rsp_ready tied high, the minimum spacing is 4 cycles between accepted requests.
- rsp_ready sampled outside RESP is ignored.
- Reset during SETUP, ACCESS or RESP:
  - The next cycle is IDLE with psel=0, penable=0 and rsp_valid=0.
  - The in-flight transfer is dropped silently and produces no response.
- rsp_err is 0 for a successful transfer.

Optional Feature:
Macro CORE_APB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle while pready=0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer is abandoned: psel and penable drop next cycle, state goes to RESP, rsp_err=1, rsp_rdata=0.
  - If pready=1 arrives in the same cycle the limit is reached, the normal completion wins.
- Not defined: no counter is built, and ACCESS waits indefinitely for pready.

Test Plan:
- Read, zero-wait: rst released; req addr=0x0800_0010, write=0; slave returns prdata=0xDEAD_BEEF with pready=1 on the first ACCESS cycle -> psel high for 2 cycles, pstrb=0, rsp_valid at accept+3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write with wait states: addr=0x0000_0004, wdata=0x1234_5678, wstrb=0xF; pready held low 3 ACCESS cycles -> paddr/pwdata/pstrb stable for 5 cycles, rsp_valid at accept+6, rsp_rdata=0.
- Error plus response backpressure: pslverr=1 with pready=1; rsp_ready held low 4 cycles -> rsp_err=1 held, req_ready=0 until the cycle after rsp_ready=1, with no new APB transfer in between.
- Back-to-back: 3 reads with rsp_ready=1 and pready=1 -> three SETUP/ACCESS pairs, accepts spaced exactly 4 cycles, responses in order.
- Reset mid-ACCESS: assert rst for 1 cycle while pready=0 -> next cycle psel=0, penable=0, rsp_valid=0, req_ready=1; no response is ever emitted for the dropped transfer.
- Timeout (CORE_APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): pready stuck low -> after 4 ACCESS cycles psel drops and rsp_valid=1 with rsp_err=1, rsp_rdata=0. Without the macro, the same stimulus keeps psel=1 indefinitely.
